// File: rtl/config_chain_loader.sv
// config_chain_loader: serialises config words LSB-first into the CGRA shift chain; define CONFIG_LOADER_PARITY_EN to add a parity output
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              Chain_Data,
  output logic              Chain_Enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
`ifdef CONFIG_LOADER_PARITY_EN
  ,
  output logic              parity
`endif
);
  localparam int NB_W = $clog2(WORD_W + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]        state;
  logic [WORD_W-1:0] shreg;
  logic [NB_W-1:0]   nbits;
  logic [CNT_W-1:0]  rem;
  logic [NB_W-1:0]   nbits_load;
  logic              last_bit;
  // Bits still owed to the chain bound the final (possibly partial) word.
  always_comb begin
    rem        = CNT_W'(CHAIN_LEN) - bit_count;
    nbits_load = (rem < CNT_W'(WORD_W)) ? NB_W'(rem) : NB_W'(WORD_W);
    last_bit   = bit_count == CNT_W'(CHAIN_LEN - 1);
  end
  assign word_ready   = state == FETCH;
  assign Chain_Enable = state == SHIFT;
  assign Chain_Data   = Chain_Enable & shreg[0];
  assign busy         = (state == FETCH) || (state == SHIFT);
  assign done         = state == DONE;
  // Load sequencer: fetch a word, shift its bits out, stop after CHAIN_LEN bits.
  always_ff @(posedge Config_Clock) begin
    if (Config_Reset) begin
      state     <= IDLE;
      shreg     <= '0;
      nbits     <= '0;
      bit_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= FETCH;
          bit_count <= '0;
        end
        FETCH: if (word_valid) begin
          shreg <= word_data;
          nbits <= nbits_load;
          state <= SHIFT;
        end
        SHIFT: begin
          shreg     <= shreg >> 1;
          bit_count <= bit_count + CNT_W'(1);
          nbits     <= nbits - NB_W'(1);
          state     <= last_bit ? DONE : (nbits == NB_W'(1)) ? FETCH : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONFIG_LOADER_PARITY_EN
  // Running XOR of every bit driven into the chain during the current load.
  always_ff @(posedge Config_Clock) begin
    if (Config_Reset || (state == IDLE && start)) parity <= 1'b0;
    else if (state == SHIFT) parity <= parity ^ shreg[0];
  end
`endif
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: scoreboard bench for config_chain_loader (WORD_W=16, CHAIN_LEN=40)
module tb_config_chain_loader;
  localparam int WORD_W = 16, CHAIN_LEN = 40, CNT_W = 16;
  logic Config_Clock = 0, Config_Reset = 1, start = 0, word_valid = 0;
  logic [WORD_W-1:0] word_data = '0;
  logic word_ready, Chain_Data, Chain_Enable, busy, done;
  logic [CNT_W-1:0] bit_count;
`ifdef CONFIG_LOADER_PARITY_EN
  logic parity;
`endif
  int total = 0, bad = 0;
  bit exp_q[$];
  int done_q[$];
  int en_cnt = 0;
  logic prev_en = 0;

  config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .Config_Clock(Config_Clock),
    .Config_Reset(Config_Reset),
    .start(start),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .Chain_Data(Chain_Data),
    .Chain_Enable(Chain_Enable),
    .busy(busy),
    .done(done),
    .bit_count(bit_count)
`ifdef CONFIG_LOADER_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  always #5 Config_Clock = ~Config_Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Config_Clock) begin
    if (Config_Reset) begin
      en_cnt = 0;
      prev_en = 0;
    end else begin
      if (Chain_Enable) begin
        en_cnt++;
        if (exp_q.size() == 0) chk("extra_enable", Chain_Enable, 0);
        else chk("chain_data", Chain_Data, exp_q.pop_front());
      end else if (Chain_Data) chk("data_zero_when_idle", Chain_Data, 0);
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          chk("done_bit_count", bit_count, done_q.pop_front());
          chk("enable_count", en_cnt, CHAIN_LEN);
          chk("done_after_last_bit", prev_en, 1);
          chk("busy_in_done", busy, 0);
        end
        en_cnt = 0;
      end
      prev_en = Chain_Enable;
    end
  end

  task automatic tick();
    @(posedge Config_Clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!word_ready && n < 200) begin
      tick();
      n++;
    end
    if (!word_ready) chk("ready_timeout", word_ready, 1);
  endtask

  task automatic run_load(input logic [WORD_W-1:0] w0, w1, w2, input int stall, input bit poke);
    logic [WORD_W-1:0] ws[3];
    int n;
    ws = '{w0, w1, w2};
    for (int i = 0; i < 3; i++) begin
      int nb = CHAIN_LEN - i * WORD_W;
      if (nb > WORD_W) nb = WORD_W;
      for (int b = 0; b < nb; b++) exp_q.push_back(ws[i][b]);
    end
    done_q.push_back(CHAIN_LEN);
    start = 1;
    tick();
    start = 0;
    chk("ready_after_start", word_ready, 1);
    chk("busy_after_start", busy, 1);
    chk("count_restart", bit_count, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && stall > 0) begin
        word_valid = 0;
        wait_ready();
        for (int s = 0; s < stall; s++) begin
          chk("stall_no_enable", Chain_Enable, 0);
          tick();
        end
      end
      word_data = ws[i];
      word_valid = 1;
      wait_ready();
      tick();
      if (i == 0 && poke) begin
        repeat (3) tick();
        chk("poke_in_shift", Chain_Enable, 1);
        start = 1;
        tick();
        start = 0;
      end
    end
    word_valid = 0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", done, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("count_hold", bit_count, CHAIN_LEN);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk("rst_ready", word_ready, 0);
    chk("rst_enable", Chain_Enable, 0);
    chk("rst_data", Chain_Data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", bit_count, 0);
    Config_Reset = 0;
    tick();
    run_load(16'hA5C3, 16'h0F0F, 16'hFFFF, 0, 0);
`ifdef CONFIG_LOADER_PARITY_EN
    chk("parity_pattern", parity, 0);
`endif
    run_load(16'hA5C3, 16'h0F0F, 16'hFFFF, 5, 0);
    run_load(16'hA5C3, 16'h0F0F, 16'hFFFF, 0, 1);
    run_load(16'hA5C3, 16'h0F0F, 16'hFFFF, 0, 0);
`ifdef CONFIG_LOADER_PARITY_EN
    run_load(16'h0001, 16'h0000, 16'h0003, 0, 0);
    chk("parity_odd", parity, 1);
    run_load(16'h0000, 16'h0000, 16'h0000, 0, 0);
    chk("parity_zero", parity, 0);
`endif
    for (int b = 0; b < WORD_W; b++) exp_q.push_back(word_data[0] ^ word_data[0] ^ 1'b0 ^ 1'b0 ? 1'b0 : 1'b0);
    exp_q.delete();
    word_data = 16'hA5C3;
    for (int b = 0; b < WORD_W; b++) exp_q.push_back(word_data[b]);
    start = 1;
    tick();
    start = 0;
    word_valid = 1;
    wait_ready();
    tick();
    repeat (5) tick();
    chk("mid_shift_enable", Chain_Enable, 1);
    Config_Reset = 1;
    exp_q.delete();
    done_q.delete();
    word_valid = 0;
    repeat (2) tick();
    Config_Reset = 0;
    chk("abort_ready", word_ready, 0);
    chk("abort_enable", Chain_Enable, 0);
    chk("abort_data", Chain_Data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", bit_count, 0);
    repeat (10) tick();
    chk("abort_stays_idle", busy, 0);
    chk("leftover_bits", exp_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Bitstream source for the CGRA configuration shift chain.
- Accepts configuration words on a valid/ready interface and serialises them one bit per cycle.
- Drives the chain head (the first cell's serial input) and a shift-enable used to gate Config_Clock to the cells.
- Stops after exactly CHAIN_LEN bits, then reports completion.

Parameters:
- WORD_W, 32, width of an input configuration word.
- CHAIN_LEN, 1024, total configuration bits in the chain (sum of all cell sizes); must be ≥ 1.
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- Config_Clock, in, 1, single clock for all logic.
- Config_Reset, in, 1, synchronous active-high reset.
- start, in, 1, begin a load; sampled only in IDLE.
- word_data, in, WORD_W, configuration word; bit 0 is shifted first.
- word_valid, in, 1, word_data valid.
- word_ready, out, 1, loader can accept a word.
- Chain_Data, out, 1, serial bit into the chain head.
- Chain_Enable, out, 1, chain shifts on this Config_Clock edge.
- busy, out, 1, load in progress.
- done, out, 1, one-cycle pulse once the last bit has shifted.
- bit_count, out, CNT_W, bits shifted in the current or last load.

Behaviour:
- Reset (synchronous, Config_Reset high at a rising edge):
  - state=IDLE.
  - word_ready, Chain_Enable, Chain_Data, busy, done = 0; bit_count = 0.
  - Shift register and per-word bit counter cleared.
- Reset mid-load aborts immediately: no further Chain_Enable. The chain cells are not reset by this block.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - busy=0, word_ready=0.
  - start=1 → FETCH; bit_count cleared in the same edge.
- FETCH:
  - busy=1, word_ready=1, Chain_Enable=0.
  - On word_valid & word_ready: load word_data into the shift register; nbits = min(WORD_W, CHAIN_LEN − bit_count); → SHIFT.
  - No valid → stay; the chain holds.
- SHIFT:
  - word_ready=0, Chain_Enable=1, Chain_Data = shreg[0].
  - Each cycle: shreg >>= 1; bit_count += 1; nbits −= 1.
  - bit_count reaching CHAIN_LEN → DONE.
  - Else nbits reaching 0 → FETCH.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE. bit_count holds CHAIN_LEN until the next start.
- Latency:
  - start accepted at edge t → word_ready=1 in cycle t+1.
  - Word accepted at edge a → first Chain_Enable in cycle a+1.
  - Last bit shifts at edge e → done=1 in cycle e+1.
  - One FETCH bubble per word, so a load with back-to-back valid words takes CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from start to done.
- Partial last word: when CHAIN_LEN mod WORD_W ≠ 0, the upper unused bits of the final word are discarded and never driven.
- Ordering: the first bit sent ends at the chain tail. Software orders the stream tail-cell first, LSB of each cell first.
- start while busy or in DONE is ignored (no queuing).
- Chain_Data is 0 whenever Chain_Enable=0.
- Simultaneous word_valid and last-bit shift: word_ready is 0 in SHIFT, so the word waits for the next FETCH cycle and is not consumed.
- All outputs are registered or decoded from state registers only; there is no combinational path from inputs to outputs except none at all.

Optional Feature:
- Macro: CONFIG_LOADER_PARITY_EN.
- When defined:
  - Adds output parity (1 bit).
  - parity = XOR of every bit driven with Chain_Enable=1 in the current load.
  - Cleared on start acceptance and on reset; stable from the done cycle until the next start.
- When not defined: no parity port and no parity logic.

Test Plan:
- Reset: hold Config_Reset 2 cycles mid-SHIFT → next cycle all outputs 0, state IDLE, no further Chain_Enable.
- Full load, WORD_W=16, CHAIN_LEN=40, words 0xA5C3, 0x0F0F, 0xFFFF (valid always 1):
  - Chain_Data sequence = LSB-first 16+16+8 bits; upper 0xFF of the third word is dropped.
  - Exactly 40 Chain_Enable cycles.
  - done one cycle after the 40th; bit_count=40.
- Valid stall: deassert word_valid for 5 cycles before word 2 → Chain_Enable=0 for those cycles, then resumes; bit sequence identical to the full-load case.
- start during busy: pulse start in SHIFT → ignored; bit_count still ends at 40 and done pulses once.
- Back-to-back loads: start again in the cycle after done → second load completes identically; bit_count restarts from 0.
- CONFIG_LOADER_PARITY_EN build with words 0x0001, 0x0000, 0x0003 (CHAIN_LEN=40) → parity=1 at done; all-zero words → parity=0.
